// File: rtl/text_console_ctrl.sv
// Write-side controller for the text-mode character RAM.
// Interprets a byte stream (printables, LF, CR, BS), tracks the cursor,
// and issues registered RAM writes. Scrolling rotates top_row and blanks
// one physical row; clearing blanks the whole RAM.
module text_console_ctrl #(
    parameter int          TextCols = 64,
    parameter int          TextRows = 32,
    parameter logic [7:0]  Blank    = 8'h20,
    localparam int         Cells    = TextCols * TextRows,
    localparam int         AW       = $clog2(Cells),
    localparam int         RW       = $clog2(TextRows),
    localparam int         CW       = $clog2(TextCols)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [RW-1:0] top_row,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          busy
);

    typedef enum logic [1:0] {sIdle, sClear, sScroll} state_t;

    localparam logic [AW-1:0] LastCell = AW'(Cells - 1);
    localparam logic [AW-1:0] LastCol  = AW'(TextCols - 1);
    localparam logic [CW-1:0] MaxCol   = CW'(TextCols - 1);
    localparam logic [RW-1:0] MaxRow   = RW'(TextRows - 1);
    localparam logic [RW:0]   RowsW    = (RW+1)'(TextRows);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] top_nxt, row_nxt, scroll_row, scroll_row_nxt;
    logic [CW-1:0] col_nxt;
    logic          pending, pending_nxt;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [7:0]    wr_data_nxt;
    logic          advance;
    logic [RW:0]   phys_sum;
    logic [RW-1:0] phys;
    logic [AW-1:0] char_addr, scroll_addr;

    assign busy     = (state != sIdle);
    assign in_ready = (state == sIdle) && !clear && !pending;

    // Physical row of the cursor: modular add by compare-and-subtract.
    always_comb begin
        phys_sum = {1'b0, top_row} + {1'b0, cur_row};
        if (phys_sum >= RowsW) phys_sum = phys_sum - RowsW;
        phys        = phys_sum[RW-1:0];
        char_addr   = AW'(phys) * AW'(TextCols) + AW'(cur_col);
        scroll_addr = AW'(scroll_row) * AW'(TextCols) + cnt;
    end

    // Next-state, cursor, and write-port decode.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_nxt      = state;
        cnt_nxt        = cnt;
        top_nxt        = top_row;
        col_nxt        = cur_col;
        row_nxt        = cur_row;
        scroll_row_nxt = scroll_row;
        pending_nxt    = pending;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        advance        = 1'b0;

        case (state)
            sClear: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cnt;
                wr_data_nxt = Blank;
                if (clear) begin
                    cnt_nxt = '0;
                end else if (cnt == LastCell) begin
                    cnt_nxt   = '0;
                    top_nxt   = '0;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    state_nxt = sIdle;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end

            sScroll: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = scroll_addr;
                wr_data_nxt = Blank;
                if (clear) pending_nxt = 1'b1;
                if (cnt == LastCol) begin
                    cnt_nxt   = '0;
                    state_nxt = sIdle;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end

            default: begin  // sIdle
                if (clear || pending) begin
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = sClear;
                end else if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = char_addr;
                        wr_data_nxt = in_data;
                        if (cur_col == MaxCol) begin
                            col_nxt = '0;
                            advance = 1'b1;
                        end else begin
                            col_nxt = cur_col + CW'(1);
                        end
                    end else if (in_data == 8'h0A) begin
                        col_nxt = '0;
                        advance = 1'b1;
                    end else if (in_data == 8'h0D) begin
                        col_nxt = '0;
                    end else if (in_data == 8'h08) begin
                        if (cur_col != '0) begin
                            col_nxt = cur_col - CW'(1);
                        end else if (cur_row != '0) begin
                            row_nxt = cur_row - RW'(1);
                            col_nxt = MaxCol;
                        end
                    end
                end

                // Bottom-row advance rotates the view and blanks the old top row.
                if (advance) begin
                    if (cur_row < MaxRow) begin
                        row_nxt = cur_row + RW'(1);
                    end else begin
                        top_nxt        = (top_row == MaxRow) ? '0 : top_row + RW'(1);
                        scroll_row_nxt = top_row;
                        cnt_nxt        = '0;
                        state_nxt      = sScroll;
                    end
                end
            end
        endcase
    end

    // State and registered write-port update, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= sClear;
            cnt        <= '0;
            top_row    <= '0;
            cur_col    <= '0;
            cur_row    <= '0;
            scroll_row <= '0;
            pending    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= Blank;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            top_row    <= top_nxt;
            cur_col    <= col_nxt;
            cur_row    <= row_nxt;
            scroll_row <= scroll_row_nxt;
            pending    <= pending_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: a reference cursor model
// pushes expected RAM writes to a queue; a monitor pops and compares them.
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  top_row;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  m_col, m_row, m_top;

    text_console_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .top_row  (top_row),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_write", {21'd0, wr_addr}, 32'h7FFFFFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                check("wr_addr", {21'd0, wr_addr}, {21'd0, e.addr});
                check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
            end
        end
    end

    task automatic push_wr(input int addr, input int data);
        wr_t e;
        e.addr = addr[10:0];
        e.data = data[7:0];
        q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2048; i++) push_wr(i, 8'h20);
        m_col = 0;
        m_row = 0;
        m_top = 0;
    endtask

    task automatic model_advance();
        if (m_row < 31) begin
            m_row++;
        end else begin
            for (int i = 0; i < 64; i++) push_wr(m_top * 64 + i, 8'h20);
            m_top = (m_top + 1) % 32;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(((m_top + m_row) % 32) * 64 + m_col, b);
            if (m_col == 63) begin
                m_col = 0;
                model_advance();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            model_advance();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 63;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Counts negedges with in_ready low, starting at the current one.
    task automatic count_low(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, {26'd0, cur_col}, m_col);
        check({tag, "_row"}, {27'd0, cur_row}, m_row);
        check({tag, "_top"}, {27'd0, top_row}, m_top);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        model_byte(b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_cursor("cursor");
    endtask

    task automatic check_idle(input string tag);
        wait_ready();
        @(negedge clk);
        check({tag, "_sb_empty"}, q.size(), 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_ready"}, {31'd0, in_ready}, 1);
        check_cursor(tag);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_wr_en", {31'd0, wr_en}, 0);

        // Power-up clear.
        model_clear();
        reset = 1'b0;
        count_low(n);
        check("init_clear_len", n, 2048);
        check_idle("init");

        // Single printable then CR.
        send_byte(8'h41);
        send_byte(8'h0D);

        // Full row of printables wraps to row 1 with no scroll.
        for (int i = 0; i < 64; i++) send_byte(8'h21 + 8'(i % 90));
        check_idle("row_wrap");

        // Backspace corner cases and an ignored control code.
        send_byte(8'h08);   // (1,0) -> (0,63)
        send_byte(8'h0D);
        send_byte(8'h08);   // (0,0) stays
        for (int i = 0; i < 5; i++) send_byte(8'h0A);
        send_byte(8'h08);   // (5,0) -> (4,63)
        send_byte(8'h07);
        send_byte(8'h78);   // col 63 write, wraps to (5,0)
        check_idle("bs");

        // Walk to bottom row and scroll with LF.
        for (int i = 0; i < 26; i++) send_byte(8'h0A);
        send_byte(8'h0A);
        count_low(n);
        check("scroll_len", n, 64);
        check_idle("scroll_lf");
        send_byte(8'h51);   // lands at physical row 0, addr 0

        // Printable at last column of bottom row triggers scroll.
        for (int i = 0; i < 63; i++) send_byte(8'h30 + 8'(i % 10));
        check_idle("scroll_wrap");

        // Clear and in_valid together: byte must be dropped.
        @(negedge clk);
        model_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1 check("clr_ready_low", {31'd0, in_ready}, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        count_low(n);
        check("req_clear_len", n, 2048);
        check_idle("req_clear");

        // Clear pulse during a scroll: scroll completes, then full clear.
        for (int i = 0; i < 32; i++) send_byte(8'h0A);
        repeat (10) @(negedge clk);
        check("mid_scroll_busy", {31'd0, busy}, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        check_idle("scroll_clear");

        // Reset in the middle of a clear restarts at address 0.
        send_byte(8'h42);
        send_byte(8'h43);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q.delete();
        model_clear();
        reset = 1'b0;
        count_low(n);
        check("reset_clear_len", n, 2048);
        check_idle("reset_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Write-side controller for the text-mode display's character RAM.
- Consumes a byte stream from the CPU/UART side through a valid/ready handshake and interprets control codes.
- Keeps a cursor and generates RAM write cycles.
- Scrolls by rotating a top-row offset that the display reader adds to its row index; it does not copy memory. Also clears the whole screen on reset and on request.

Parameters:
TextCols, 64, characters per text row
TextRows, 32, text rows per screen
Blank, 8'h20, fill character for clears

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_data  input  8  character or control code
in_valid  input  1  in_data valid
in_ready  output  1  controller accepts in_data this cycle
clear  input  1  full-screen clear request (pulse)
wr_en  output  1  text RAM write strobe
wr_addr  output  $clog2(TextCols*TextRows)  text RAM address, 0-indexed
wr_data  output  8  text RAM write data
top_row  output  $clog2(TextRows)  physical RAM row shown as screen row 0
cur_col  output  $clog2(TextCols)  cursor column (logical)
cur_row  output  $clog2(TextRows)  cursor row (logical, relative to top_row)
busy  output  1  clear or scroll sequence in progress

Behaviour:
- Reset is synchronous and active-high on clk, and aborts any sequence. State <= sClear, clear counter <= 0, top_row/cur_col/cur_row <= 0, wr_en <= 0, wr_addr <= 0, wr_data <= Blank, clear-pending <= 0.
- States:
  - sClear: writes Blank to addresses 0..TextCols*TextRows-1, one per cycle. It then sets top_row, cur_col and cur_row to 0 and goes to sIdle.
  - sIdle: accepts characters.
  - sScroll: writes Blank to the TextCols addresses of one physical row, one per cycle, then goes to sIdle.
- busy = state != sIdle. in_ready = (state == sIdle) && !clear && !clear-pending (combinational).
- Handshake: a byte is consumed when in_valid && in_ready. in_data may change freely when in_ready is low.
- Write outputs are registered. A printable character accepted in cycle N produces wr_en=1 in cycle N+1, with:
  - wr_data = in_data
  - wr_addr = phys*TextCols + cur_col (cursor value at N)
  - phys = (top_row + cur_row) wrapped mod TextRows by compare-and-subtract, no divider.
- wr_en is 1 in every sClear/sScroll cycle and otherwise 0 except after a printable accept.
- Codes:
  - 0x20..0x7E printable: write, then cur_col+1. If cur_col was TextCols-1: cur_col <= 0 and line-advance.
  - 0x0A LF: cur_col <= 0 and line-advance (acts as CR+LF).
  - 0x0D CR: cur_col <= 0.
  - 0x08 BS: if cur_col>0, cur_col-1. Else if cur_row>0, cur_row-1 and cur_col <= TextCols-1. Else no change. BS never erases.
  - Any other code is consumed and ignored; no write.
- Line-advance:
  - If cur_row < TextRows-1: cur_row+1.
  - Otherwise cur_row stays TextRows-1 and top_row <= top_row+1 (wrapping at TextRows-1 -> 0). State then goes to sScroll, clearing physical row old top_row (the new bottom row).
  - A printable write in the same cycle as a wrap-induced scroll completes in cycle N+1. Scroll writes start in N+2.
- clear:
  - In sIdle, clear takes priority over in_valid in the same cycle (no byte accepted) and enters sClear next cycle.
  - A clear asserted in sClear/sScroll sets clear-pending. On return to sIdle it enters sClear immediately, and clear-pending is cleared on sClear entry.
  - A clear during sClear restarts the address counter at 0.
- Arithmetic:
  - All counters wrap by explicit compare, so non-power-of-two TextCols/TextRows are legal.
  - wr_addr never exceeds TextCols*TextRows-1.
- Latency:
  - Full clear occupies TextCols*TextRows cycles; scroll occupies TextCols cycles.
  - in_ready is low for exactly those cycles.

Test Plan:
- Reset release -> 2048 consecutive wr_en cycles, wr_addr 0..2047 with wr_data 0x20; then in_ready=1, busy=0, top_row=0, cursor (0,0).
- Send 'A' (0x41) at cursor (0,0) -> next cycle wr_en=1, wr_addr=0, wr_data=0x41; cur_col=1. Then send 0x0D -> cur_col=0, no write.
- Send 64 printables on row 0 -> last write to addr 63; cursor becomes (row 1, col 0); no scroll.
- Cursor row 31 with top_row=0, send 0x0A -> top_row=1, cursor (31,0), in_ready low 64 cycles, writes 0x20 to addr 0..63. Next printable at col 0 -> wr_addr=0.
- BS at (0,0) -> no change. BS at (5,0) -> cursor (4,63), no write. Send 0x07 -> consumed, no write, cursor unchanged.
- clear and in_valid in the same sIdle cycle -> byte not accepted, 2048-cycle clear follows. A clear pulse mid-scroll -> scroll finishes, then a full clear runs. Reset mid-clear -> wr_addr restarts at 0.
